// File: rtl/noise_flip_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the noise-injection sequencer.
package noise_pkg;

    localparam int DIM  = 256;
    localparam int IDXW = 8;

    localparam logic [IDXW-1:0] SEED_DEFAULT  = 8'hA5;
    localparam logic [IDXW-1:0] FLIPS_DEFAULT = 8'd64;

    // Fibonacci feedback taps: bits 7, 5, 4, 3.
    localparam logic [IDXW-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        IDLE,
        FLIP,
        HOLD
    } flip_state_t;

    // Flip counts above 255 saturate; 255 is the LFSR period, so every flip stays distinct.
    function automatic logic [IDXW-1:0] clamp_flips(input logic [IDXW:0] f);
        return f[IDXW] ? '1 : f[IDXW-1:0];
    endfunction

endpackage

// File: rtl/noise_flip_ctrl_if.sv
// Input and output valid/ready streams of the noise-injection sequencer.
interface noise_flip_ctrl_if #(
    parameter int DIM = noise_pkg::DIM
);
    logic           in_valid;
    logic           in_ready;
    logic [DIM-1:0] in_hv;
    logic           out_valid;
    logic           out_ready;
    logic [DIM-1:0] out_hv;

    modport slave (
        input  in_valid, in_hv, out_ready,
        output in_ready, out_valid, out_hv
    );

    modport master (
        output in_valid, in_hv, out_ready,
        input  in_ready, out_valid, out_hv
    );
endinterface

// File: rtl/noise_flip_ctrl_lfsr.sv
// 8-bit maximal-length Fibonacci LFSR supplying flip positions; a zero seed maps to the default.
module flip_lfsr #(
    parameter int IDXW = noise_pkg::IDXW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [IDXW-1:0] load_val,
    input  logic            step,
    output logic [IDXW-1:0] state
);
    import noise_pkg::*;

    logic [IDXW-1:0] state_q;
    logic [IDXW-1:0] state_d;

    // Next state: load (zero substituted) has priority over stepping.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = (load_val == '0) ? SEED_DEFAULT : load_val;
        end else if (step) begin
            state_d = {state_q[IDXW-2:0], ^(state_q & LFSR_TAPS)};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEED_DEFAULT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/noise_flip_ctrl.sv
// Noise-injection sequencer: accepts a hypervector, flips N distinct LFSR-chosen bits, returns it.
module noise_flip_ctrl #(
    parameter int DIM  = noise_pkg::DIM,
    parameter int IDXW = noise_pkg::IDXW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IDXW-1:0]  cfg_seed,
    input  logic [IDXW:0]    cfg_flips,
    noise_flip_ctrl_if.slave bus,
    output logic             busy
);
    import noise_pkg::*;

    flip_state_t     state_q, state_d;
    logic [DIM-1:0]  work_q, work_d;
    logic [IDXW-1:0] remain_q, remain_d;
    logic [IDXW-1:0] flips_q, flips_d;

    logic            lfsr_load;
    logic            lfsr_step;
    logic [IDXW-1:0] lfsr_pos;
    logic            in_ready_c;

    flip_lfsr #(
        .IDXW(IDXW)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (lfsr_load),
        .load_val(cfg_seed),
        .step    (lfsr_step),
        .state   (lfsr_pos)
    );

    // Next-state, datapath and handshake decode; configuration wins over an input vector.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        remain_d   = remain_q;
        flips_d    = flips_q;
        lfsr_load  = 1'b0;
        lfsr_step  = 1'b0;
        in_ready_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_c = !cfg_we;
                if (cfg_we) begin
                    flips_d   = clamp_flips(cfg_flips);
                    lfsr_load = 1'b1;
                end else if (bus.in_valid) begin
                    work_d   = bus.in_hv;
                    remain_d = flips_q;
                    state_d  = (flips_q == '0) ? HOLD : FLIP;
                end
            end
            FLIP: begin
                work_d[lfsr_pos] = ~work_q[lfsr_pos];
                lfsr_step        = 1'b1;
                remain_d         = remain_q - IDXW'(1);
                if (remain_q == IDXW'(1)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            remain_q <= '0;
            flips_q  <= FLIPS_DEFAULT;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            remain_q <= remain_d;
            flips_q  <= flips_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_hv    = work_q;
    assign busy          = (state_q != IDLE);

endmodule
